// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column widths, GF(2^8) helpers, engine FSM states.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    HOLD = 2'd2
  } mc_state_e;

  // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return gf_xtime(a) ^ a;
  endfunction

  // 9 = 8 + 1
  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(a)));
    return x8 ^ a;
  endfunction

  // 0x0B = 8 + 2 + 1
  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = gf_xtime(a);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  // 0x0D = 8 + 4 + 1
  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = gf_xtime(gf_xtime(a));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  // 0x0E = 8 + 4 + 2
  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational single-column MixColumns / InvMixColumns. Row 0 is the MSB byte.
module mix_col_word
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [AES_COL_W-1:0] col_in,
  input  logic                 inv,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [AES_COL_W-1:0] fwd_res;
  logic [AES_COL_W-1:0] inv_res;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Forward matrix rows {02,03,01,01} rotated per row
  always_comb begin
    fwd_res = '0;
    fwd_res[31:24] = gf_xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    fwd_res[23:16] = a0 ^ gf_xtime(a1) ^ gf_mul3(a2) ^ a3;
    fwd_res[15:8]  = a0 ^ a1 ^ gf_xtime(a2) ^ gf_mul3(a3);
    fwd_res[7:0]   = gf_mul3(a0) ^ a1 ^ a2 ^ gf_xtime(a3);
  end

  if (INV_EN) begin : g_inv
    // Inverse matrix rows {0E,0B,0D,09} rotated per row
    always_comb begin
      inv_res = '0;
      inv_res[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      inv_res[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      inv_res[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      inv_res[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end
  end else begin : g_no_inv
    assign inv_res = '0;
  end

  assign col_out = (INV_EN && inv) ? inv_res : fwd_res;

endmodule

// File: rtl/mix_cols_engine.sv
// AES MixColumns / InvMixColumns / bypass engine, LANES columns per cycle,
// valid/ready on both sides, result held in HOLD until the downstream takes it.
module mix_cols_engine
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_inv,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_cols_engine: LANES must be 1, 2 or 4");
  end

  localparam int         GROUPS   = (LANES > 0) ? (4 / LANES) : 1;
  localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

  mc_state_e              state_q, state_d;
  logic [1:0]             col_cnt_q, col_cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;
  logic                   inv_q, inv_d;
  logic                   byp_q, byp_d;
  logic [AES_STATE_W-1:0] res_q, res_d;

  logic accept;

  logic [1:0]           lane_idx [LANES];
  logic [AES_COL_W-1:0] lane_in  [LANES];
  logic [AES_COL_W-1:0] lane_out [LANES];

  assign accept = in_valid && in_ready;

  // Each lane works on column col_cnt*LANES+gi; column c sits at bit 96-32c, i.e. {~c,5'b0}
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 2'(int'(col_cnt_q) * LANES + gi);
    assign lane_in[gi]  = data_q[{~lane_idx[gi], 5'd0} +: AES_COL_W];

    mix_col_word #(.INV_EN(INV_EN)) u_word (
      .col_in (lane_in[gi]),
      .inv    (inv_q),
      .col_out(lane_out[gi])
    );
  end

  // State and column-group counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Next state: IDLE -> PROC on accept, PROC walks the groups, HOLD waits for the sink
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = PROC;
          col_cnt_d = '0;
        end
      end
      PROC: begin
        if (col_cnt_q == LAST_GRP) begin
          state_d   = HOLD;
          col_cnt_d = '0;
        end else begin
          col_cnt_d = col_cnt_q + 2'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = in_valid ? PROC : IDLE;
          col_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        col_cnt_d = '0;
      end
    endcase
  end

  // Handshake outputs; in HOLD the input side is open exactly when the result leaves
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    in_ready = 1'b1;
      PROC:    in_ready = 1'b0;
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next values: latch the transaction on accept, fill result groups in PROC
  always_comb begin
    data_d = data_q;
    inv_d  = inv_q;
    byp_d  = byp_q;
    res_d  = res_q;
    if (accept) begin
      data_d = in_data;
      inv_d  = in_inv && INV_EN;
      byp_d  = in_bypass;
    end
    if (state_q == PROC) begin
      for (int l = 0; l < LANES; l++) begin
        res_d[{~lane_idx[l], 5'd0} +: AES_COL_W] = byp_q ? lane_in[l] : lane_out[l];
      end
    end
  end

  // Datapath registers; a reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      inv_q  <= 1'b0;
      byp_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      data_q <= data_d;
      inv_q  <= inv_d;
      byp_q  <= byp_d;
      res_q  <= res_d;
    end
  end

  assign out_data = res_q;

endmodule

// File: tb/tb_mix_cols_engine.sv
// Self-checking bench for mix_cols_engine: matrix-level GF(2^8) model plus
// directed vectors (FIPS-197 round 1, single-column vectors, bypass,
// backpressure, reset mid-transaction).
module tb_mix_cols_engine;

  parameter int LANES  = 1;
  parameter bit INV_EN = 1'b1;
  localparam int LAT = 4 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         in_bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  always #5 clk = ~clk;

  mix_cols_engine #(.LANES(LANES), .INV_EN(INV_EN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_inv   (in_inv),
    .in_bypass(in_bypass),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  longint cycle = 0;

  logic [127:0] exp_q [$];
  longint       acc_q [$];
  bit           lat_done = 1'b0;

  // Directed vectors
  localparam logic [127:0] T1_IN   = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] T1_OUT  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] T1B_IN  = {4{32'hdb135345}};
  localparam logic [127:0] T1B_OUT = {4{32'h8e4da1bc}};
  localparam logic [127:0] T2_IN   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] T2_OUT  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] T4_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product, column by column
  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [127:0] r = '0;
    logic [31:0]  col;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      col = s[96-32*c +: 32];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gf_mul(coef[(k - row + 4) % 4], col[24-8*k +: 8]);
        r[96-32*c+24-8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] expect_of(input logic [127:0] d, input bit inv, input bit byp);
    if (byp) return d;
    return model(d, inv && INV_EN);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Compare process: every negedge, check handshake and data against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      lat_done = 1'b0;
    end else begin
      cycle++;
      if (exp_q.size() == 0) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
      end else if (!out_valid) begin
        chk("proc_in_ready", in_ready, 0);
        chk("proc_busy", busy, 1);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        chk("hold_in_ready", in_ready, out_ready);
        chk("hold_busy", busy, 1);
        if (!lat_done) begin
          chk("latency", 128'(cycle - acc_q[0]), 128'(LAT + 1));
          lat_done = 1'b1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          lat_done = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(expect_of(in_data, in_inv, in_bypass));
        acc_q.push_back(cycle);
      end
    end
  end

  // Offer one transaction (call just after a posedge); scramble side inputs after accept
  task automatic send(input logic [127:0] d, input bit inv, input bit byp);
    int w;
    in_data = d; in_inv = inv; in_bypass = byp; in_valid = 1'b1;
    for (w = 0; w < 100; w++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (w == 100) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_inv = ~inv; in_bypass = ~byp; in_data = ~d;
  endtask

  // Wait for a result and compare it to a hand-computed value
  task automatic recv(input logic [127:0] exp, input string name);
    int w;
    for (w = 0; w < 100; w++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (w == 100) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: actual out_valid=0 required 1", name);
    end
    chk(name, out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t3_exp;
    logic [127:0] t3b_exp;
    int           wait_cyc;

    // Pin the model against literals
    chk("model_t1", model(T1_IN, 1'b0), T1_OUT);
    chk("model_t2", model(T2_IN, 1'b0), T2_OUT);
    chk("model_t3", model(T2_OUT, 1'b1), T2_IN);
    chk("model_t3b", model(T1B_OUT, 1'b1), T1B_IN);

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 / T2 forward
    send(T1_IN, 1'b0, 1'b0);   recv(T1_OUT, "t1_fwd_cols");
    send(T1B_IN, 1'b0, 1'b0);  recv(T1B_OUT, "t1_fwd_rep");
    send(T2_IN, 1'b0, 1'b0);   recv(T2_OUT, "t2_fwd_fips");

    // T3 inverse (forward result when the inverse logic is not built)
    t3_exp  = INV_EN ? T2_IN  : model(T2_OUT, 1'b0);
    t3b_exp = INV_EN ? T1B_IN : model(T1B_OUT, 1'b0);
    send(T2_OUT, 1'b1, 1'b0);  recv(t3_exp, "t3_inv_fips");
    send(T1B_OUT, 1'b1, 1'b0); recv(t3b_exp, "t3_inv_rep");

    // T4 bypass overrides inverse
    send(T4_IN, 1'b1, 1'b1);   recv(T4_IN, "t4_bypass");

    // T5 backpressure, then same-cycle hand-over to the next transaction
    out_ready = 1'b0;
    send(T1_IN, 1'b0, 1'b0);
    recv(T1_OUT, "t5_first");
    in_data = T2_IN; in_inv = 1'b0; in_bypass = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_ready", in_ready, 0);
      chk("t5_hold_data", out_data, T1_OUT);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_same_cycle_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    recv(T2_OUT, "t5_second");

    // T6 reset in the middle of PROC
    wait_cyc = (LAT > 2) ? 2 : LAT - 1;
    send(T2_IN, 1'b0, 1'b0);
    repeat (wait_cyc) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_stale_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(T1_IN, 1'b0, 1'b0);   recv(T1_OUT, "t6_after_reset");

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
